// File: rtl/handshake_constant_arbiter.sv
// Round-robin arbiter that turns N dataless control tokens into one elastic
// channel carrying the winner's constant and index through a one-entry output register.
module handshake_constant_arbiter #(
   parameter int                          N_REQ      = 4,
   parameter int                          DATA_WIDTH = 32,
   parameter logic [N_REQ*DATA_WIDTH-1:0] CONST_INIT = '0,
   localparam int                         IDX_W      = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [N_REQ-1:0]      ctrl_valid,
   output logic [N_REQ-1:0]      ctrl_ready,
   output logic [DATA_WIDTH-1:0] outs,
   output logic [IDX_W-1:0]      outs_idx,
   output logic                  outs_valid,
   input  logic                  outs_ready
);

   logic [IDX_W-1:0]      rr_ptr;
   logic [IDX_W-1:0]      winner;
   logic [IDX_W-1:0]      rr_ptr_next;
   logic                  any_valid;
   logic                  load_en;
   logic [DATA_WIDTH-1:0] win_const;

   // (base + off) mod N_REQ; both operands are already below N_REQ.
   function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input int unsigned      off);
      int unsigned sum;
      sum = 32'(base) + off;
      if (sum >= 32'(N_REQ)) sum = sum - 32'(N_REQ);
      return IDX_W'(sum);
   endfunction

   assign load_en = !outs_valid || outs_ready;

   // Scan from the farthest offset down so the one closest to rr_ptr wins.
   // NOTE: every variable driven here gets a default first, so no path can infer a latch.
   always_comb begin
      winner    = '0;
      any_valid = 1'b0;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (ctrl_valid[wrap_add(rr_ptr, unsigned'(k))]) begin
            winner    = wrap_add(rr_ptr, unsigned'(k));
            any_valid = 1'b1;
         end
      end
   end

   always_comb begin
      ctrl_ready = '0;
      if (load_en && any_valid) ctrl_ready[winner] = 1'b1;
   end

   always_comb begin
      win_const = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (winner == IDX_W'(i)) win_const = CONST_INIT[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   assign rr_ptr_next = (winner == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(winner + 1'b1);

   // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         outs_valid <= 1'b0;
         outs       <= '0;
         outs_idx   <= '0;
         rr_ptr     <= '0;
      end else if (load_en) begin
         if (any_valid) begin
            outs       <= win_const;
            outs_idx   <= winner;
            outs_valid <= 1'b1;
            rr_ptr     <= rr_ptr_next;
         end else begin
            outs_valid <= 1'b0;
         end
      end
   end

endmodule
